osc_freq_meter: RTL and testbench
=================================

OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent oscillator inputs measured in parallel.
REQ-002 SHALL have parameter COUNTER_LENGTH, default 32: per-channel edge-counter width.
REQ-003 SHALL have parameter WINDOW_LENGTH, default 24: width of the measurement-window length input.
REQ-004 SHALL have port CLK, input, 1: the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port RESETN, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port OSC_IN, input, CHANNELS: raw oscillator outputs, asynchronous to CLK, one bit per channel.
REQ-007 SHALL have port START, input, 1: request to begin one measurement.
REQ-008 SHALL have port WINDOW, input, WINDOW_LENGTH: measurement length in CLK cycles, sampled on START acceptance.
REQ-009 SHALL have port BUSY, output, 1: high from START acceptance through the DONE cycle.
REQ-010 SHALL have port DONE, output, 1: single-cycle pulse marking the end of a measurement.
REQ-011 SHALL have port COUNT, output, CHANNELS*COUNTER_LENGTH: result registers, channel i at bits [i*COUNTER_LENGTH +: COUNTER_LENGTH].
REQ-012 SHALL have port SATURATED, output, CHANNELS: per-channel overflow flag for the last result.

Function
REQ-013 SHALL implement FSM IDLE -> ARM -> MEASURE -> FINISH -> IDLE.
REQ-014 SHALL accept START only in IDLE; START while BUSY is ignored, not queued.
REQ-015 On START acceptance (cycle t), SHALL latch WINDOW, assert BUSY and enter ARM at t+1, clearing all working counters.
REQ-016 SHALL stay in MEASURE for exactly the latched WINDOW cycles (t+2 to t+1+WINDOW), counting one per synchronised rising edge per channel.
REQ-017 With latched WINDOW = 0, SHALL skip MEASURE (ARM -> FINISH) and report all counts 0.
REQ-018 In FINISH, SHALL copy working counters to COUNT and SATURATED and pulse DONE for one cycle; BUSY drops the next cycle.
REQ-019 COUNT and SATURATED SHALL hold the previous result unchanged until the next FINISH.
REQ-020 Each OSC_IN bit SHALL pass a 2-flop synchroniser followed by a rising-edge detector; edge-to-count latency is 3 CLK cycles.
REQ-021 An edge detected in ARM or FINISH SHALL NOT be counted.
REQ-022 Correct counts require oscillator frequency below CLK/2; higher rates undercount and are outside this block's guarantee.
REQ-023 START and the last MEASURE cycle coinciding SHALL NOT start a new measurement; START is re-evaluated only in IDLE.

Reset
REQ-024 RESETN low SHALL asynchronously force IDLE, BUSY=0, DONE=0, COUNT=0, SATURATED=0, synchroniser flops 0, working counters 0.
REQ-025 Reset during MEASURE SHALL abort the measurement with no DONE pulse and no result update.

Configuration
REQ-026 With OSC_METER_SATURATE_EN defined, working counters SHALL stick at all-ones and set the channel's sticky overflow bit instead of incrementing past it.
REQ-027 Without OSC_METER_SATURATE_EN, counters SHALL wrap modulo 2^COUNTER_LENGTH and SATURATED SHALL be constant 0.

Structure
REQ-028 FSM state encodings and default parameter values SHALL reside in shared package osc_meter_pkg.
REQ-029 Synchroniser plus edge detector SHALL be sub-module osc_edge_sync, instantiated CHANNELS times.

Verification
REQ-030 CHANNELS=4, OSC_IN periods 10/20/40/80 CLK, WINDOW=800, START -> DONE at t+802; COUNT = 80/40/20/10 (+/-1).
REQ-031 WINDOW=0, START -> DONE at t+2, all COUNT = 0, BUSY high for t+1..t+2.
REQ-032 START pulsed again mid-MEASURE -> ignored; exactly one DONE; COUNT from the first window only.
REQ-033 COUNTER_LENGTH=4, period 4, WINDOW=100 -> with macro COUNT=15, SATURATED=1; without macro COUNT=25 mod 16=9, SATURATED=0.
REQ-034 RESETN low at MEASURE cycle 50 -> immediate IDLE, outputs 0, no DONE; next START measures normally.
REQ-035 Two back-to-back measurements, differing WINDOW -> COUNT holds first result until second DONE, then updates.

Source files
------------

// File: rtl/osc_meter_pkg.sv
// Shared definitions for the oscillator frequency meter: default parameter
// values and the measurement FSM state encoding.
package osc_meter_pkg;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_COUNTER_LENGTH = 32;
  localparam int DEF_WINDOW_LENGTH  = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_FINISH  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for one asynchronous oscillator bit, followed by a
// registered rising-edge detector. An input edge produces a one-cycle rise
// pulse that the counter consumes three clocks after the edge is first sampled.
module osc_edge_sync
  import osc_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic osc,
  output logic rise
);

  // sync[0] catches metastability, sync[1] is the clean sample, sync[2] its history
  logic [2:0] sync;

  // Shift the oscillator through the synchroniser and register the 0->1 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[1:0], osc};
      rise <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/osc_freq_meter.sv
// Multi-channel oscillator frequency meter. START (accepted only in IDLE)
// latches WINDOW; the meter arms for one cycle, counts synchronised rising
// edges on every OSC_IN bit for WINDOW clock cycles, then publishes the counts
// in COUNT together with a one-cycle DONE pulse. COUNT/SATURATED hold their
// value until the next measurement finishes.
// Optional feature: define OSC_METER_SATURATE_EN to make the working counters
// stick at all-ones and raise SATURATED instead of wrapping.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int COUNTER_LENGTH = DEF_COUNTER_LENGTH,
  parameter int WINDOW_LENGTH  = DEF_WINDOW_LENGTH
) (
  input  logic                               CLK,
  input  logic                               RESETN,
  input  logic [CHANNELS-1:0]                OSC_IN,
  input  logic                               START,
  input  logic [WINDOW_LENGTH-1:0]           WINDOW,
  output logic                               BUSY,
  output logic                               DONE,
  output logic [CHANNELS*COUNTER_LENGTH-1:0] COUNT,
  output logic [CHANNELS-1:0]                SATURATED
);

  meter_state_t             state;
  logic [WINDOW_LENGTH-1:0] remaining;   // latched window, counted down in MEASURE
  logic                     enter_finish;

  // The next edge moves into FINISH: an empty window straight from ARM, or the last MEASURE cycle
  assign enter_finish = ((state == ST_ARM) && (remaining == '0)) ||
                        ((state == ST_MEASURE) && (remaining == WINDOW_LENGTH'(1)));

  // Measurement sequencer with registered BUSY and DONE
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_IDLE;
      remaining <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= enter_finish;
      case (state)
        ST_IDLE: begin
          if (START) begin
            remaining <= WINDOW;
            BUSY      <= 1'b1;
            state     <= ST_ARM;
          end
        end
        ST_ARM: begin
          state <= enter_finish ? ST_FINISH : ST_MEASURE;
        end
        ST_MEASURE: begin
          remaining <= remaining - WINDOW_LENGTH'(1);
          if (enter_finish) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic                      rise;
      logic [COUNTER_LENGTH-1:0] work_cnt;
      logic [COUNTER_LENGTH-1:0] cnt_next;
      logic [COUNTER_LENGTH-1:0] result;

      osc_edge_sync u_edge (
        .clk   (CLK),
        .rst_n (RESETN),
        .osc   (OSC_IN[gi]),
        .rise  (rise)
      );

`ifdef OSC_METER_SATURATE_EN
      logic work_ovf;
      logic ovf_next;
      logic result_ovf;

      // Next working count: cleared in ARM, sticks at all-ones with a sticky overflow in MEASURE
      always_comb begin
        cnt_next = work_cnt;
        ovf_next = work_ovf;
        if (state == ST_ARM) begin
          cnt_next = '0;
          ovf_next = 1'b0;
        end else if ((state == ST_MEASURE) && rise) begin
          if (&work_cnt) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = work_cnt + COUNTER_LENGTH'(1);
          end
        end
      end

      // Overflow flag tracks the working counter and is published with the count
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          work_ovf   <= 1'b0;
          result_ovf <= 1'b0;
        end else begin
          work_ovf <= ovf_next;
          if (enter_finish) begin
            result_ovf <= ovf_next;
          end
        end
      end

      assign SATURATED[gi] = result_ovf;
`else
      // Next working count: cleared in ARM, wraps modulo 2^COUNTER_LENGTH in MEASURE
      always_comb begin
        cnt_next = work_cnt;
        if (state == ST_ARM) begin
          cnt_next = '0;
        end else if ((state == ST_MEASURE) && rise) begin
          cnt_next = work_cnt + COUNTER_LENGTH'(1);
        end
      end

      assign SATURATED[gi] = 1'b0;
`endif

      // Working counter, and result capture that includes an edge landing in the final MEASURE cycle
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          work_cnt <= '0;
          result   <= '0;
        end else begin
          work_cnt <= cnt_next;
          if (enter_finish) begin
            result <= cnt_next;
          end
        end
      end

      assign COUNT[gi*COUNTER_LENGTH +: COUNTER_LENGTH] = result;
    end
  endgenerate

endmodule

// File: tb/tb_osc_freq_meter.sv
// Self-checking bench for osc_freq_meter. Oscillators are square waves toggled
// on the falling clock edge with known half-periods, so the expected edge
// count of every window is derived from the oscillator waveform and the
// three-cycle edge-to-count latency. Expected results are queued when START
// is driven and compared when DONE appears. A second instance
// (1 channel, 4-bit counters) covers counter overflow.
module tb_osc_freq_meter;

  localparam int CH  = 4;
  localparam int CL  = 32;
  localparam int WL  = 24;
  localparam int SCL = 4;
  localparam int HALF_S = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic [CH-1:0]    osc = '0;
  logic             start = 1'b0;
  logic [WL-1:0]    window = '0;
  logic             busy, done;
  logic [CH*CL-1:0] count;
  logic [CH-1:0]    sat;

  logic             osc_s = 1'b0;
  logic             start_s = 1'b0;
  logic [WL-1:0]    window_s = '0;
  logic             busy_s, done_s;
  logic [SCL-1:0]   count_s;
  logic [0:0]       sat_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int half [CH] = '{5, 10, 20, 40};

  typedef struct {
    int               t;
    int               w;
    logic [CH*CL-1:0] cnt;
    logic [CH-1:0]    sat;
  } exp_t;

  exp_t sb[$];
  exp_t sb_s[$];
  exp_t mon_e;
  exp_t mon_es;
  logic [CH*CL-1:0] last_count = '0;
  logic done_d = 1'b0;

  osc_freq_meter #(.CHANNELS(CH), .COUNTER_LENGTH(CL), .WINDOW_LENGTH(WL)) dut (
    .CLK(clk), .RESETN(resetn), .OSC_IN(osc), .START(start), .WINDOW(window),
    .BUSY(busy), .DONE(done), .COUNT(count), .SATURATED(sat)
  );

  osc_freq_meter #(.CHANNELS(1), .COUNTER_LENGTH(SCL), .WINDOW_LENGTH(WL)) dut_small (
    .CLK(clk), .RESETN(resetn), .OSC_IN(osc_s), .START(start_s), .WINDOW(window_s),
    .BUSY(busy_s), .DONE(done_s), .COUNT(count_s), .SATURATED(sat_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic osc_at(input int h, input int n);
    return (n >= 0) && (((n / h) % 2) == 1);
  endfunction

  // rising edges of an oscillator seen by the synchroniser, indexed by drive cycle j
  function automatic int rises(input int h, input int lo, input int hi);
    int r = 0;
    for (int j = lo; j <= hi; j++)
      if (osc_at(h, j) && !osc_at(h, j - 1)) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // oscillator stimulus, driven on the falling edge from the cycle count
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) osc[i] = osc_at(half[i], cyc);
    osc_s = osc_at(HALF_S, cyc);
  end

  // result monitor for the main instance
  always @(negedge clk) begin
    if (done_d) begin
      check("busy_drop", busy, 0);
      check("done_single", done, 0);
    end
    done_d = done;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.t + mon_e.w + 1);
        check("busy_at_done", busy, 1);
        for (int c = 0; c < CH; c++)
          check($sformatf("count_ch%0d_w%0d", c, mon_e.w), count[c*CL +: CL], mon_e.cnt[c*CL +: CL]);
        check("saturated", sat, mon_e.sat);
        $display("meas W=%0d t=%0d count=%0d/%0d/%0d/%0d", mon_e.w, mon_e.t,
                 count[0 +: CL], count[CL +: CL], count[2*CL +: CL], count[3*CL +: CL]);
        last_count = count;
      end
    end
  end

  // result monitor for the small overflow instance
  always @(negedge clk) begin
    if (done_s) begin
      if (sb_s.size() == 0) begin
        check("unexpected_done_s", 1, 0);
      end else begin
        mon_es = sb_s.pop_front();
        check("done_cycle_s", cyc, mon_es.t + mon_es.w + 1);
        check("count_s", count_s, mon_es.cnt[SCL-1:0]);
        check("saturated_s", sat_s, mon_es.sat[0]);
        $display("small W=%0d count=%0d sat=%0d", mon_es.w, count_s, sat_s);
      end
    end
  end

  task automatic run_meas(input int w);
    exp_t e;
    @(negedge clk);
    window = w;
    start  = 1'b1;
    e.t = cyc + 1;
    e.w = w;
    e.cnt = '0;
    for (int c = 0; c < CH; c++) e.cnt[c*CL +: CL] = rises(half[c], e.t - 2, e.t + w - 3);
    e.sat = '0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t es;
    int   r;
    int   n;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    for (int c = 0; c < CH; c++) check($sformatf("rst_count_ch%0d", c), count[c*CL +: CL], 0);
    check("rst_sat", sat, 0);
    check("rst_count_s", count_s, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // nominal four-channel measurement
    run_meas(800);
    wait_done(1000);

    // empty window and single-cycle window
    run_meas(0);
    wait_done(20);
    run_meas(1);
    wait_done(20);

    // START pulsed mid-measurement must be ignored
    run_meas(300);
    repeat (100) @(negedge clk);
    window = 5;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(400);
    repeat (350) @(negedge clk);

    // counter overflow on the small instance
    @(negedge clk);
    window_s = 100;
    start_s  = 1'b1;
    es.t = cyc + 1;
    es.w = 100;
    r = rises(HALF_S, es.t - 2, es.t + 97);
    es.cnt = '0;
    es.sat = '0;
`ifdef OSC_METER_SATURATE_EN
    es.cnt[SCL-1:0] = (r > 15) ? SCL'(15) : SCL'(r);
    es.sat[0] = (r > 15);
`else
    es.cnt[SCL-1:0] = SCL'(r % 16);
`endif
    sb_s.push_back(es);
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (sb_s.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_s.size() != 0) begin
      check("timeout_s", sb_s.size(), 0);
      sb_s.delete();
    end
    repeat (5) @(negedge clk);

    // reset in the middle of MEASURE aborts without DONE or result update
    run_meas(200);
    repeat (50) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int c = 0; c < CH; c++) check($sformatf("abort_count_ch%0d", c), count[c*CL +: CL], 0);
    check("abort_sat", sat, 0);
    void'(sb.pop_back());
    last_count = '0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", done, 0);
    run_meas(64);
    wait_done(100);

    // back-to-back measurements: result holds until the second DONE
    run_meas(200);
    wait_done(300);
    run_meas(120);
    repeat (60) @(negedge clk);
    for (int c = 0; c < CH; c++)
      check($sformatf("hold_count_ch%0d", c), count[c*CL +: CL], last_count[c*CL +: CL]);
    wait_done(200);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
